// File: rtl/vec_normalizer.sv
// vec_normalizer: normalizes an N_ELEM signed fixed-point vector via an external 1/sqrt unit.
// Optional out_sat status port enabled by defining VECNORM_SAT_STATUS_EN.
module vec_normalizer #(
   parameter int INT_WIDTH   = 12,
   parameter int FRACT_WIDTH = 4,
   parameter int N_ELEM      = 4,
   localparam int W          = INT_WIDTH + FRACT_WIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_ELEM*W-1:0] in_vec,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N_ELEM*W-1:0] out_vec,
   output logic              out_zero,
`ifdef VECNORM_SAT_STATUS_EN
   output logic              out_sat,
`endif
   output logic [W-1:0]      isq_data,
   output logic              isq_valid,
   input  logic              isq_ready,
   input  logic [W-1:0]      isq_result,
   input  logic              isq_result_valid,
   output logic              isq_result_ready
);
   localparam int IW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
   localparam int PW = 2 * W + 2;
   localparam logic [W-1:0] SAT_HI = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] SAT_LO = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, SUMSQ, CHECK, ISQ_REQ, ISQ_WAIT, SCALE, OUT} state_t;

   state_t              r_state, w_next;
   logic [IW-1:0]       r_idx;
   logic signed [W-1:0] r_elem [N_ELEM];
   logic signed [W-1:0] r_out  [N_ELEM];
   logic [W-1:0]        r_acc, r_res, r_isq_data;
   logic                r_in_ready, r_zero;
`ifdef VECNORM_SAT_STATUS_EN
   logic                r_sat;
`endif
   logic                w_accept, w_last, w_acc_sat, w_hi, w_lo;
   logic signed [W:0]   w_a, w_b;
   logic signed [PW-1:0] w_prod, w_shift, w_sum;
   logic signed [W-1:0] w_scaled;

   // Shared multiplier: squares the element in SUMSQ, scales it by the inverse root in SCALE.
   assign w_accept = (r_state == IDLE) && in_valid && r_in_ready;
   assign w_last   = r_idx == IW'(N_ELEM - 1);
   assign w_a      = {r_elem[r_idx][W-1], r_elem[r_idx]};
   assign w_b      = (r_state == SUMSQ) ? w_a : $signed({1'b0, r_res});
   assign w_prod   = PW'(w_a) * PW'(w_b);
   assign w_shift  = w_prod >>> FRACT_WIDTH;
   assign w_sum    = $signed({{(PW-W){1'b0}}, r_acc}) + w_shift;
   assign w_acc_sat = w_sum > $signed({{(PW-W){1'b0}}, SAT_HI});
   assign w_hi     = w_shift > $signed({{(PW-W){1'b0}}, SAT_HI});
   assign w_lo     = w_shift < $signed({{(PW-W){1'b1}}, SAT_LO});
   assign w_scaled = w_hi ? SAT_HI : w_lo ? SAT_LO : w_shift[W-1:0];

   // State register; reset aborts any vector in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Next-state sequencing through sum-of-squares, inverse-sqrt handshake and scaling.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:     w_next = w_accept ? SUMSQ : IDLE;
         SUMSQ:    w_next = w_last ? CHECK : SUMSQ;
         CHECK:    w_next = (r_acc == '0) ? OUT : ISQ_REQ;
         ISQ_REQ:  w_next = isq_ready ? ISQ_WAIT : ISQ_REQ;
         ISQ_WAIT: w_next = isq_result_valid ? SCALE : ISQ_WAIT;
         SCALE:    w_next = w_last ? OUT : SCALE;
         OUT:      w_next = out_ready ? IDLE : OUT;
         default:  w_next = IDLE;
      endcase
   end

   // Datapath: latch input, accumulate saturating sum of squares, capture root, scale with clamp.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_ready <= 1'b0;
         r_idx      <= '0;
         r_acc      <= '0;
         r_res      <= '0;
         r_isq_data <= '0;
         r_zero     <= 1'b0;
`ifdef VECNORM_SAT_STATUS_EN
         r_sat      <= 1'b0;
`endif
         for (int i = 0; i < N_ELEM; i++) begin
            r_elem[i] <= '0;
            r_out[i]  <= '0;
         end
      end else begin
         r_in_ready <= (w_next == IDLE);
         if (w_accept) begin
            for (int i = 0; i < N_ELEM; i++) r_elem[i] <= in_vec[i*W +: W];
            r_acc  <= '0;
            r_idx  <= '0;
            r_zero <= 1'b0;
`ifdef VECNORM_SAT_STATUS_EN
            r_sat  <= 1'b0;
`endif
         end
         if (r_state == SUMSQ) begin
            r_acc <= w_acc_sat ? SAT_HI : w_sum[W-1:0];
            r_idx <= w_last ? '0 : r_idx + 1'b1;
`ifdef VECNORM_SAT_STATUS_EN
            if (w_acc_sat) r_sat <= 1'b1;
`endif
         end
         if (r_state == CHECK) begin
            if (r_acc == '0) begin
               r_zero <= 1'b1;
               for (int i = 0; i < N_ELEM; i++) r_out[i] <= '0;
            end else r_isq_data <= r_acc;
         end
         if (r_state == ISQ_WAIT && isq_result_valid) r_res <= isq_result;
         if (r_state == SCALE) begin
            r_out[r_idx] <= w_scaled;
            r_idx        <= w_last ? '0 : r_idx + 1'b1;
`ifdef VECNORM_SAT_STATUS_EN
            if (w_hi || w_lo) r_sat <= 1'b1;
`endif
         end
      end
   end

   for (genvar g = 0; g < N_ELEM; g++) begin : g_pack
      assign out_vec[g*W +: W] = r_out[g];
   end

   assign in_ready         = r_in_ready;
   assign out_valid        = (r_state == OUT);
   assign out_zero         = r_zero;
   assign isq_data         = r_isq_data;
   assign isq_valid        = (r_state == ISQ_REQ);
   assign isq_result_ready = (r_state == ISQ_WAIT);
`ifdef VECNORM_SAT_STATUS_EN
   assign out_sat          = r_sat;
`endif
endmodule

// File: tb/tb_vec_normalizer.sv
// tb_vec_normalizer: randomized and directed checks of vec_normalizer against a reference model.
module tb_vec_normalizer;
   localparam int W = 16;
   localparam int N = 4;

   logic           clk = 0, rst_n = 0;
   logic           in_valid = 0, in_ready;
   logic [N*W-1:0] in_vec = '0;
   logic           out_valid, out_ready = 0, out_zero;
   logic [N*W-1:0] out_vec;
`ifdef VECNORM_SAT_STATUS_EN
   logic           out_sat;
`endif
   logic [W-1:0]   isq_data, isq_result;
   logic           isq_valid, isq_ready, isq_result_valid, isq_result_ready;

   int             errors = 0, checks = 0;
   logic [N*W-1:0] exp_vec;
   logic [W-1:0]   exp_acc;
   logic           exp_zero, exp_sat;
   logic           tb_busy = 0;
   int             stub_rdly = 0, stub_lat = 0, stub_phase, stub_cnt;
   logic [W-1:0]   stub_r = '0;
   logic           hs_next;

   vec_normalizer dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
      .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .out_zero(out_zero),
`ifdef VECNORM_SAT_STATUS_EN
      .out_sat(out_sat),
`endif
      .isq_data(isq_data), .isq_valid(isq_valid), .isq_ready(isq_ready),
      .isq_result(isq_result), .isq_result_valid(isq_result_valid),
      .isq_result_ready(isq_result_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   // Reference: sum of floored e^2/16 with saturation, then floor(e*r/16) clamped to 16-bit signed.
   task automatic model(input logic [N*W-1:0] v, input logic [W-1:0] r);
      longint acc = 0, e, p;
      logic sat = 0;
      for (int i = 0; i < N; i++) begin
         e = longint'($signed(v[i*W +: W]));
         acc = acc + (e * e) / 16;
         if (acc > 32767) begin acc = 32767; sat = 1; end
      end
      exp_acc  = acc[15:0];
      exp_zero = (acc == 0);
      exp_vec  = '0;
      if (!exp_zero)
         for (int i = 0; i < N; i++) begin
            e = longint'($signed(v[i*W +: W]));
            p = (e * longint'(r)) >>> 4;
            if (p > 32767) begin p = 32767; sat = 1; end
            if (p < -32768) begin p = -32768; sat = 1; end
            exp_vec[i*W +: W] = p[15:0];
         end
      exp_sat = sat;
   endtask

   // Inverse-sqrt peer stub: delayed ready, samples data a cycle after handshake,
   // returns a one-cycle result pulse, and emits stray result pulses while idle.
   initial begin
      isq_ready = 0; isq_result_valid = 0; isq_result = '0;
      stub_phase = 0; stub_cnt = 0; hs_next = 0;
      forever begin
         @(posedge clk); #1;
         isq_result_valid = 0;
         if (!rst_n) begin
            stub_phase = 0; stub_cnt = 0; isq_ready = 0; hs_next = 0;
         end else begin
            case (stub_phase)
               0: if (hs_next) begin isq_ready = 0; stub_phase = 1; stub_cnt = 0; end
                  else if (isq_valid) begin
                     if (stub_cnt >= stub_rdly) isq_ready = 1; else stub_cnt++;
                  end else if ($urandom_range(0, 5) == 0) begin
                     isq_result = 16'hDEAD; isq_result_valid = 1;
                  end
               1: begin stub_phase = 2; stub_cnt = 0; end
               default: if (stub_cnt >= stub_lat) begin
                     isq_result = stub_r; isq_result_valid = 1; stub_phase = 0; stub_cnt = 0;
                  end else stub_cnt++;
            endcase
            hs_next = isq_valid && isq_ready;
         end
      end
   end

   // Per-cycle comparison of DUT outputs against the model whenever they are meaningful.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid) begin
            chk("out_vec", out_vec, exp_vec);
            chk("out_zero", out_zero, exp_zero);
`ifdef VECNORM_SAT_STATUS_EN
            chk("out_sat", out_sat, exp_sat);
`endif
         end
         if (isq_valid || isq_result_ready) chk("isq_data", isq_data, exp_acc);
         if (tb_busy) chk("in_ready_busy", in_ready, 0);
         if (tb_busy && exp_zero) chk("no_isq_on_zero", {isq_valid, isq_result_ready}, 0);
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
      if (!in_ready) chk("in_ready_timeout", in_ready, 1);
   endtask

   task automatic send(input logic [N*W-1:0] v);
      wait_ready();
      in_vec = v; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0; in_vec = {$urandom, $urandom};
      tb_busy = 1;
   endtask

   task automatic run_vec(input logic [N*W-1:0] v, input logic [W-1:0] r, input int rdly,
                          input int lat, input int odly, output logic [N*W-1:0] got,
                          output logic got_zero, output logic [W-1:0] got_isq);
      int n = 0;
      model(v, r);
      stub_r = r; stub_rdly = rdly; stub_lat = lat;
      send(v);
      while (!out_valid && n < 500) begin @(posedge clk); #1; n++; end
      got = out_vec; got_zero = out_zero; got_isq = isq_data;
      if (!out_valid) begin
         chk("out_valid_timeout", out_valid, 1);
         tb_busy = 0;
         return;
      end
      if (exp_zero) chk("zero_latency_ok", n <= N + 2, 1);
      for (int i = 0; i < odly; i++) begin @(posedge clk); #1; end
      chk("out_valid_held", out_valid, 1);
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0; tb_busy = 0;
      chk("out_valid_drop", out_valid, 0);
   endtask

   task automatic chk_reset_vals(input string nm);
      chk(nm, {in_ready, out_valid, out_zero, isq_valid, isq_result_ready}, 0);
      chk({nm, "_vec"}, out_vec, 0);
      chk({nm, "_isq"}, isq_data, 0);
`ifdef VECNORM_SAT_STATUS_EN
      chk({nm, "_sat"}, out_sat, 0);
`endif
   endtask

   initial begin
      logic [N*W-1:0] got, v;
      logic           gz;
      logic [W-1:0]   gi, r;
      int             n;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      rst_n = 1;
      @(posedge clk); #1;
      chk("in_ready_after_reset", in_ready, 1);

      run_vec(64'h0000_0000_0000_0010, 16'h0010, 0, 0, 0, got, gz, gi);
      chk("t1_isq", gi, 16'h0010); chk("t1_vec", got, 64'h0000_0000_0000_0010); chk("t1_zero", gz, 0);
      run_vec(64'h0000_0000_0000_0020, 16'h0008, 1, 1, 0, got, gz, gi);
      chk("t2_isq", gi, 16'h0040); chk("t2_vec", got, 64'h0000_0000_0000_0010);
      run_vec(64'h0000_0000_0040_FFD0, 16'h0003, 0, 2, 1, got, gz, gi);
      chk("t3_isq", gi, 16'h0190); chk("t3_vec", got, 64'h0000_0000_000C_FFF7);
      chk("t3_model", exp_vec, 64'h0000_0000_000C_FFF7);
      run_vec(64'h0, 16'h0010, 0, 0, 0, got, gz, gi);
      chk("t4_zero", gz, 1); chk("t4_vec", got, 0);
      run_vec(64'h0000_0000_7FFF_7FFF, 16'h0FFF, 0, 0, 0, got, gz, gi);
      chk("t5_isq", gi, 16'h7FFF); chk("t5_vec", got, 64'h0000_0000_7FFF_7FFF);
      chk("t5_model_sat", exp_sat, 1);
      run_vec(64'h0000_0000_0040_FFD0, 16'h0003, 5, 3, 10, got, gz, gi);
      chk("t6_vec", got, 64'h0000_0000_000C_FFF7);

      // Reset while waiting for the inverse-sqrt result.
      model(64'h0000_0000_0000_0020, 16'h0008);
      stub_r = 16'h0008; stub_rdly = 0; stub_lat = 30;
      send(64'h0000_0000_0000_0020);
      n = 0;
      while (!isq_result_ready && n < 100) begin @(posedge clk); #1; n++; end
      chk("reach_isq_wait", isq_result_ready, 1);
      #2; rst_n = 0; tb_busy = 0;
      #2; chk_reset_vals("mid_reset");
      repeat (3) @(posedge clk);
      #3; rst_n = 1;
      @(posedge clk); #1;
      chk("in_ready_post_abort", in_ready, 1);
      run_vec(64'h0000_0000_0000_0010, 16'h0010, 0, 0, 0, got, gz, gi);
      chk("post_reset_vec", got, 64'h0000_0000_0000_0010);

      for (int k = 0; k < 40; k++) begin
         for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
               0:       v[i*W +: W] = 16'($signed($urandom_range(0, 6)) - 3);
               1:       v[i*W +: W] = 16'($signed($urandom_range(0, 512)) - 256);
               2:       v[i*W +: W] = 16'($urandom);
               default: v[i*W +: W] = 16'($signed($urandom_range(0, 4096)) - 2048);
            endcase
         end
         r = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 16'h400));
         run_vec(v, r, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), got, gz, gi);
         chk("rand_vec", got, exp_vec);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end
endmodule
